// File: rtl/dcache_mem_pkg.sv
// dcache_mem_pkg: shared defines and types for the data-cache memory slice.
// Macros below form the shared define set (widths, load modes, chip-enable
// and byte-enable encodings, FSM state encodings). They are guarded so a
// second definition site cannot clash.
`ifndef DCACHE_MEM_DEFINES
`define DCACHE_MEM_DEFINES
`define DATA_WIDTH      32
`define DADDR_WIDTH     6
`define DBWEB_WIDTH     4
`define MEM_MODE_WIDTH  2
`define MEM_BYTE        2'd0
`define MEM_HWORD       2'd1
`define MEM_WORD        2'd2
`define CHIP_EN         1'b0
`define CHIP_DIS        1'b1
`define DC_BWEB_WR_ALL  4'b0000
`define DC_BWEB_RD      4'b1111
`define ZERO            32'h0000_0000
`define DC_ST_INIT      1'b0
`define DC_ST_RUN       1'b1
`endif

package dcache_mem_pkg;
  typedef enum logic {
    ST_INIT = `DC_ST_INIT,
    ST_RUN  = `DC_ST_RUN
  } dc_state_e;

  localparam int DEPTH = 1 << `DADDR_WIDTH;
endpackage

// File: rtl/dcache_mem_load_align.sv
// load_align: combinational lane select and sign/zero extension of a raw
// memory word for byte / halfword / word loads.
//   rdata    - raw word
//   mode     - load size
//   uns      - 1: zero-extend, 0: sign-extend
//   off      - byte offset within the word
//   data     - aligned, extended result
//   err      - misaligned offset or undefined mode
module load_align
  import dcache_mem_pkg::*;
(
  input  logic [`DATA_WIDTH-1:0]     rdata,
  input  logic [`MEM_MODE_WIDTH-1:0] mode,
  input  logic                       uns,
  input  logic [1:0]                 off,
  output logic [`DATA_WIDTH-1:0]     data,
  output logic                       err
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    data = `ZERO;
    err  = 1'b0;
    b    = rdata[8*off +: 8];
    h    = off[1] ? rdata[31:16] : rdata[15:0];
    case (mode)
      `MEM_BYTE:  data = {{24{b[7] & ~uns}}, b};
      `MEM_HWORD: begin
        if (off[0]) err  = 1'b1;
        else        data = {{16{h[15] & ~uns}}, h};
      end
      `MEM_WORD: begin
        // Misaligned word still returns the raw word; only err flags it.
        data = rdata;
        err  = (off != 2'd0);
      end
      default:    err = 1'b1;
    endcase
  end
endmodule

// File: rtl/dcache_mem.sv
// dcache_mem: single-port data-cache word memory with a post-reset clear
// sweep and a one-cycle read pipeline that also aligns/extends loads.
//   clk, rst       - clock, synchronous active-high reset
//   dcache_addr    - word address
//   dcache_ceb     - chip enable (active low)
//   dcache_bweb    - per-byte write enable (active low); all ones = read
//   dcache_wdata   - lane-shifted write data
//   ld_mode/ld_unsigned/ld_offset - load shape, captured with the read
//   dcache_rdata   - raw word of the last read (held between reads)
//   ld_data        - aligned/extended load result (held between reads)
//   ld_valid       - pulse one cycle after an accepted read
//   ld_err         - pulse with ld_valid on misaligned / illegal load
//   busy           - clear sweep in progress
module dcache_mem
  import dcache_mem_pkg::*;
#(
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [`DADDR_WIDTH-1:0]    dcache_addr,
  input  logic                       dcache_ceb,
  input  logic [`DBWEB_WIDTH-1:0]    dcache_bweb,
  input  logic [`DATA_WIDTH-1:0]     dcache_wdata,
  input  logic [`MEM_MODE_WIDTH-1:0] ld_mode,
  input  logic                       ld_unsigned,
  input  logic [1:0]                 ld_offset,
  output logic [`DATA_WIDTH-1:0]     dcache_rdata,
  output logic [`DATA_WIDTH-1:0]     ld_data,
  output logic                       ld_valid,
  output logic                       ld_err,
  output logic                       busy
);
  logic [`DATA_WIDTH-1:0]     mem [DEPTH];
  dc_state_e                  state_q, state_d;
  logic [`DADDR_WIDTH-1:0]    cnt_q, cnt_d;
  logic                       clr_we, rd_en, wr_en;
  logic [1:0]                 vld_pipe;
  logic [`DATA_WIDTH-1:0]     rdata_q;
  logic [`MEM_MODE_WIDTH-1:0] mode_q;
  logic                       uns_q;
  logic [1:0]                 off_q;
  logic                       al_err;

  // Next-state: sweep one word per cycle, leave INIT after the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_INIT: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT_CLEAR ? ST_INIT : ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = (state_q == ST_INIT);
  assign rd_en = !rst && (state_q == ST_RUN) && (dcache_ceb == `CHIP_EN)
                 && (dcache_bweb == `DC_BWEB_RD);
  assign wr_en = !rst && (state_q == ST_RUN) && (dcache_ceb == `CHIP_EN)
                 && (dcache_bweb != `DC_BWEB_RD);

  // Array has no reset; it is only cleared by the sweep.
  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      mem[cnt_q] <= `ZERO;
    end else if (wr_en) begin
      for (int i = 0; i < `DBWEB_WIDTH; i++)
        if (!dcache_bweb[i]) mem[dcache_addr][8*i +: 8] <= dcache_wdata[8*i +: 8];
    end
  end

  // Read stage. Load-shape regs reset to an aligned word load so that
  // ld_data resolves to zero while the raw word is zero.
  assign vld_pipe[0] = rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      rdata_q     <= `ZERO;
      mode_q      <= `MEM_WORD;
      uns_q       <= 1'b1;
      off_q       <= 2'd0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (rd_en) begin
        rdata_q <= mem[dcache_addr];
        mode_q  <= ld_mode;
        uns_q   <= ld_unsigned;
        off_q   <= ld_offset;
      end
    end
  end

  load_align u_align (
    .rdata (rdata_q),
    .mode  (mode_q),
    .uns   (uns_q),
    .off   (off_q),
    .data  (ld_data),
    .err   (al_err)
  );

  assign dcache_rdata = rdata_q;
  assign ld_valid     = vld_pipe[1];
  assign ld_err       = vld_pipe[1] & al_err;
endmodule

// File: tb/tb_dcache_mem.sv
module tb_dcache_mem;
  localparam int DEPTH = 1 << `DADDR_WIDTH;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [`DADDR_WIDTH-1:0]    dcache_addr;
  logic                       dcache_ceb;
  logic [`DBWEB_WIDTH-1:0]    dcache_bweb;
  logic [`DATA_WIDTH-1:0]     dcache_wdata;
  logic [`MEM_MODE_WIDTH-1:0] ld_mode;
  logic                       ld_unsigned;
  logic [1:0]                 ld_offset;
  logic [`DATA_WIDTH-1:0]     dcache_rdata, ld_data;
  logic                       ld_valid, ld_err, busy;

  dcache_mem #(.INIT_CLEAR(1'b1)) dut (
    .clk(clk), .rst(rst), .dcache_addr(dcache_addr), .dcache_ceb(dcache_ceb),
    .dcache_bweb(dcache_bweb), .dcache_wdata(dcache_wdata), .ld_mode(ld_mode),
    .ld_unsigned(ld_unsigned), .ld_offset(ld_offset), .dcache_rdata(dcache_rdata),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_err(ld_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Reference model state
  logic [31:0] mem_m [DEPTH];
  int          init_left = 0;
  bit          started = 0;
  logic        pend_v = 0, pend_err = 0;
  logic [31:0] pend_rd = 0, pend_ld = 0;
  logic        cur_v, cur_err, cur_rst;
  logic [31:0] cur_rd, cur_ld;
  logic [31:0] last_rd = 0, last_ld = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Load result derived from plain shifts and masks.
  function automatic void model_load(input logic [31:0] w, input int mode, input bit uns,
                                     input int off, output logic [31:0] d, output logic e);
    logic [31:0] v;
    d = 0; e = 0;
    case (mode)
      0: begin
        v = (w >> (8 * off)) & 32'hFF;
        d = (!uns && v > 127) ? (v | 32'hFFFF_FF00) : v;
      end
      1: begin
        if (off % 2 == 1) e = 1;
        else begin
          v = (w >> (8 * off)) & 32'hFFFF;
          d = (!uns && v > 32767) ? (v | 32'hFFFF_0000) : v;
        end
      end
      2: begin d = w; e = (off != 0); end
      default: e = 1;
    endcase
  endfunction

  // Present one request for the next edge and predict its effect.
  task automatic drive(input logic ceb, input logic [3:0] bweb, input int addr,
                       input logic [31:0] wd, input int mode, input bit uns, input int off);
    bit acc;
    dcache_ceb   = ceb;
    dcache_bweb  = bweb;
    dcache_addr  = addr[`DADDR_WIDTH-1:0];
    dcache_wdata = wd;
    ld_mode      = mode[1:0];
    ld_unsigned  = uns;
    ld_offset    = off[1:0];
    acc = !rst && started && init_left == 0 && ceb == 1'b0;
    pend_v = 0;
    if (acc && bweb == 4'hF) begin
      pend_v  = 1;
      pend_rd = mem_m[addr];
      model_load(mem_m[addr], mode, uns, off, pend_ld, pend_err);
    end else if (acc) begin
      for (int i = 0; i < 4; i++)
        if (!bweb[i]) mem_m[addr][8*i +: 8] = wd[8*i +: 8];
    end
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b1, 4'hF, 0, 0, 2, 0, 0);
  endtask

  task automatic rd(input int addr, input int mode, input bit uns, input int off);
    drive(1'b0, 4'hF, addr, 0, mode, uns, off);
  endtask

  // Counts busy cycles from reset release; bounded so a stuck busy ends.
  task automatic count_busy(input string nm);
    int c = 0;
    while (busy === 1'b1 && c < 4 * DEPTH) begin
      c++;
      rd($urandom_range(DEPTH - 1), 2, 0, 0);  // must be ignored
    end
    chk(nm, c, DEPTH);
  endtask

  // Compare process: every cycle after the first reset edge.
  always @(posedge clk) begin
    cur_rst = rst; cur_v = pend_v; cur_err = pend_err; cur_rd = pend_rd; cur_ld = pend_ld;
    #2;
    if (cur_rst) begin
      started = 1;
      init_left = DEPTH;
      last_rd = 0; last_ld = 0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
      chk("rst_rdata", dcache_rdata, 0);
      chk("rst_ld_data", ld_data, 0);
      chk("rst_valid", {31'b0, ld_valid}, 0);
      chk("rst_err", {31'b0, ld_err}, 0);
      chk("rst_busy", {31'b0, busy}, 1);
    end else if (started) begin
      if (init_left > 0) init_left--;
      chk("busy", {31'b0, busy}, {31'b0, init_left > 0});
      chk("ld_valid", {31'b0, ld_valid}, {31'b0, cur_v});
      chk("ld_err", {31'b0, ld_err}, {31'b0, cur_v & cur_err});
      if (cur_v) begin last_rd = cur_rd; last_ld = cur_ld; end
      chk("rdata", dcache_rdata, last_rd);
      chk("ld_data", ld_data, last_ld);
    end
  end

  initial begin
    rst = 1'b1;
    dcache_ceb = 1'b1; dcache_bweb = 4'hF; dcache_addr = 0; dcache_wdata = 0;
    ld_mode = 2; ld_unsigned = 0; ld_offset = 0;
    @(negedge clk);
    idle(); idle();
    rst = 1'b0;
    count_busy("sweep_len");

    // Cleared memory reads back zero
    rd(4, 2, 0, 0);
    chk("clr_addr4", ld_data, 32'h0);
    rd(DEPTH - 1, 2, 0, 0);
    chk("clr_top", dcache_rdata, 32'h0);

    // Write then immediate read
    drive(1'b0, 4'b0000, 4, 32'hDEADBEEF, 2, 0, 0);
    rd(4, 2, 0, 0);
    chk("wr_rd_valid", {31'b0, ld_valid}, 1);
    chk("wr_rd_rdata", dcache_rdata, 32'hDEADBEEF);
    chk("wr_rd_ld", ld_data, 32'hDEADBEEF);
    rd(4, 0, 0, 3);
    chk("byte_s_off3", ld_data, 32'hFFFFFFDE);
    rd(4, 0, 1, 0);
    chk("byte_u_off0", ld_data, 32'h000000EF);
    rd(4, 1, 1, 2);
    chk("hw_u_off2", ld_data, 32'h0000DEAD);
    idle();
    chk("hold_ld", ld_data, 32'h0000DEAD);
    drive(1'b0, 4'b1011, 4, 32'h00AA0000, 2, 0, 0);
    rd(4, 2, 0, 0);
    chk("partial_wr", ld_data, 32'hDEAABEEF);
    rd(4, 1, 0, 1);
    chk("hw_off1_err", {31'b0, ld_err}, 1);
    chk("hw_off1_data", ld_data, 32'h0);
    rd(4, 2, 0, 2);
    chk("w_off2_err", {31'b0, ld_err}, 1);
    chk("w_off2_data", ld_data, 32'hDEAABEEF);
    rd(4, 3, 0, 0);
    chk("bad_mode_err", {31'b0, ld_err}, 1);

    // Reset with a read presented, then reset again at sweep cycle 10
    rst = 1'b1;
    rd(4, 2, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) rd(i, 2, 0, 0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    count_busy("sweep_restart_len");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int sel = $urandom_range(9);
      if (sel < 5)
        rd($urandom_range(DEPTH - 1), $urandom_range(3), $urandom_range(1), $urandom_range(3));
      else if (sel < 9)
        drive(1'b0, 4'($urandom_range(14)), $urandom_range(DEPTH - 1), $urandom, 2, 0, 0);
      else
        drive(1'b1, 4'($urandom_range(15)), $urandom_range(DEPTH - 1), $urandom, 2, 0, 0);
    end
    idle(); idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
